// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC constants, flit type and small helper functions
//                used by the router top, the injection queue and the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W       = 32;
    localparam int INJ_DEPTH    = 8;
    localparam int STARVE_LIMIT = 15;

    typedef logic [FLIT_W-1:0] flit_t;

    // Next value of a saturating wait counter: cleared whenever the head is
    // not waiting, otherwise counts up and sticks at the limit.
    function automatic logic [7:0] starve_next(input logic [7:0] cnt,
                                               input logic       waiting,
                                               input logic [7:0] limit);
        logic [7:0] nxt;
        nxt = 8'd0;
        if (waiting) begin
            nxt = (cnt == limit) ? cnt : cnt + 8'd1;
        end
        return nxt;
    endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/flit_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : flit_fifo_mem
//  Description : DEPTH x FLIT_W register array, synchronous write port and
//                asynchronous read port. Contents are intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_fifo_mem
    import noc_pkg::*;
#(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::INJ_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [FLIT_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [FLIT_W-1:0]        rd_data
);

    logic [FLIT_W-1:0] mem_q [DEPTH];

    // Write the offered flit into the addressed slot; storage needs no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read so the head flit is visible straight from registers
    assign rd_data = mem_q[rd_addr];

endmodule : flit_fifo_mem
`default_nettype wire

// File: rtl/injection_queue.sv
`default_nettype none
// ============================================================================
//  Module      : injection_queue
//  Description : Per-node injection FIFO in front of the router injection
//                engine. Presents the head flit, pops on grant and flags
//                starvation when the head is denied for too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module injection_queue
    import noc_pkg::*;
#(
    parameter int FLIT_W       = noc_pkg::FLIT_W,
    parameter int DEPTH        = noc_pkg::INJ_DEPTH,
    parameter int STARVE_LIMIT = noc_pkg::STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLIT_W-1:0]        enq_flit,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    output logic [FLIT_W-1:0]        inject_flit,
    output logic                     inj_bit,
    input  logic                     injection_status,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     starved
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_OCC_W = $clog2(DEPTH) + 1;
    localparam logic [c_OCC_W-1:0] c_FULL  = c_OCC_W'(DEPTH);
    localparam logic [7:0]        c_LIMIT = 8'(STARVE_LIMIT);

    logic [c_PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [c_OCC_W-1:0] occ_q,     occ_d;
    logic [7:0]         starve_q,  starve_d;

    logic w_push;
    logic w_pop;
    logic w_not_empty;
    logic w_not_full;

    // Status flags come only from registered occupancy, so ready never
    // depends on this cycle's grant and no loop forms through the router.
    assign w_not_empty = (occ_q != '0);
    assign w_not_full  = (occ_q != c_FULL);
    assign w_push      = enq_valid && w_not_full;
    assign w_pop       = w_not_empty && injection_status;

    assign enq_ready = w_not_full;
    assign inj_bit   = w_not_empty;
    assign occupancy = occ_q;
    assign starved   = (starve_q == c_LIMIT);

    // Next-state for pointers, occupancy and the starvation counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (w_pop && !w_push) begin
            occ_d = occ_q - 1'b1;
        end
        // Waiting means a valid head that the router did not take this cycle
        starve_d = starve_next(starve_q, w_not_empty && !injection_status, c_LIMIT);
    end

    // Control state register; memory contents are left untouched by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            starve_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            starve_q <= starve_d;
        end
    end

    flit_fifo_mem #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (wr_ptr_q),
        .wr_data (enq_flit),
        .rd_addr (rd_ptr_q),
        .rd_data (inject_flit)
    );

endmodule : injection_queue
`default_nettype wire

// File: tb/tb_injection_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_injection_queue
//  Description : Self-checking bench for injection_queue using a flit
//                scoreboard plus a reference occupancy/starvation model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_injection_queue;
    import noc_pkg::*;

    localparam int c_DEPTH = noc_pkg::INJ_DEPTH;
    localparam int c_LIMIT = noc_pkg::STARVE_LIMIT;

    logic        clk;
    logic        rst_n;
    logic [31:0] enq_flit;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] inject_flit;
    logic        inj_bit;
    logic        injection_status;
    logic [3:0]  occupancy;
    logic        starved;

    injection_queue #(
        .FLIT_W       (32),
        .DEPTH        (c_DEPTH),
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enq_flit         (enq_flit),
        .enq_valid        (enq_valid),
        .enq_ready        (enq_ready),
        .inject_flit      (inject_flit),
        .inj_bit          (inj_bit),
        .injection_status (injection_status),
        .occupancy        (occupancy),
        .starved          (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          sc    = 0;
    logic [31:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against model at the
    // falling edge, then advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [31:0] f, input logic g);
        logic had;
        logic full;
        enq_valid        = v;
        enq_flit         = f;
        injection_status = g;
        @(negedge clk);
        chk("inj_bit",   {31'd0, inj_bit},   {31'd0, sb.size() != 0});
        chk("enq_ready", {31'd0, enq_ready}, {31'd0, sb.size() != c_DEPTH});
        chk("occupancy", {28'd0, occupancy}, 32'(sb.size()));
        chk("starved",   {31'd0, starved},   {31'd0, sc == c_LIMIT});
        had  = (sb.size() != 0);
        full = (sb.size() == c_DEPTH);
        if (g && had) begin
            chk("inject_flit", inject_flit, sb.pop_front());
            n_pop++;
        end
        if (v && !full) sb.push_back(f);
        if (!had || g) sc = 0;
        else if (sc < c_LIMIT) sc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int pop_start;
        logic v;
        logic g;
        logic acc;

        rst_n = 1'b0;
        enq_valid = 1'b0;
        enq_flit = '0;
        injection_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset then idle
        chk("rst_inj_bit",   {31'd0, inj_bit},   32'd0);
        chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
        chk("rst_occupancy", {28'd0, occupancy}, 32'd0);
        chk("rst_starved",   {31'd0, starved},   32'd0);
        cycle(1'b0, 32'h0, 1'b0);

        // Fill to full, then a rejected ninth push
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b0);
        chk("full_occ",   {28'd0, occupancy}, 32'd8);
        chk("full_ready", {31'd0, enq_ready}, 32'd0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("full_head",  inject_flit,        32'h0000_0001);
        chk("rej_occ",    {28'd0, occupancy}, 32'd8);

        // Drain in order
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        // Simultaneous push/pop at full, then at seven
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0);
        cycle(1'b1, 32'h55, 1'b1);
        chk("fullpp_occ", {28'd0, occupancy}, 32'd7);
        cycle(1'b1, 32'h66, 1'b1);
        chk("pp_occ",     {28'd0, occupancy}, 32'd7);
        for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        // Wrap-around with random gaps on both sides
        sent = 0;
        pop_start = n_pop;
        for (int c = 0; c < 400 && (sent < 20 || sb.size() != 0); c++) begin
            v   = (sent < 20) && ($urandom_range(0, 2) != 0);
            g   = ($urandom_range(0, 1) != 0);
            acc = v && (sb.size() < c_DEPTH);
            cycle(v, 32'hA0 + 32'(sent), g);
            if (acc) sent++;
        end
        chk("wrap_sent",  32'(sent),              32'd20);
        chk("wrap_left",  32'(sb.size()),         32'd0);
        chk("wrap_pops",  32'(n_pop - pop_start), 32'd20);
        cycle(1'b0, 32'h0, 1'b0);

        // Starvation: 15 denied cycles, grant on the 16th
        cycle(1'b1, 32'h77, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'h0, 1'b0);
        chk("starve_set", {31'd0, starved}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("starve_clr", {31'd0, starved}, 32'd0);
        chk("starve_inj", {31'd0, inj_bit}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0);

        // Reset asserted in the middle of a starvation episode
        cycle(1'b1, 32'h88, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_starved", {31'd0, starved},   32'd0);
        chk("mid_rst_inj",     {31'd0, inj_bit},   32'd0);
        chk("mid_rst_occ",     {28'd0, occupancy}, 32'd0);
        chk("mid_rst_ready",   {31'd0, enq_ready}, 32'd1);
        sb.delete();
        sc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 32'h99, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_injection_queue
`default_nettype wire

// File: doc/injection_queue.md
# injection_queue

Per-node injection buffer that sits directly upstream of the router's injection engine. It accepts flits from the local processing element and holds them in a FIFO. It presents the head flit on the router's `inject_flit`/`inj_bit` inputs and pops it when the router returns `injection_status` (grant). It also tracks how long the head flit has waited for a free output slot and flags injection starvation, which is a known hazard of bufferless deflection routing.

## Interface
- `FLIT_W`, 32, flit width; must match the router datapath.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `STARVE_LIMIT`, 15, consecutive denied cycles before `starved` asserts; range 1..255.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enq_flit`  in  FLIT_W  flit from local PE.
- `enq_valid`  in  1  PE offers `enq_flit` this cycle.
- `enq_ready`  out  1  queue can accept a flit (= not full).
- `inject_flit`  out  FLIT_W  head flit to router.
- `inj_bit`  out  1  head flit valid (= not empty).
- `injection_status`  in  1  router grant: head flit consumed this cycle.
- `occupancy`  out  $clog2(DEPTH)+1  current entry count.
- `starved`  out  1  head flit denied for ≥ STARVE_LIMIT consecutive cycles.

## Operation
- Push: on a rising edge where `enq_valid && enq_ready`, write `enq_flit` at the write pointer and increment the write pointer.
- Pop: on a rising edge where `inj_bit && injection_status`, increment the read pointer. `injection_status` is ignored while `inj_bit` = 0.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `occupancy` is a separate counter:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop.
- Full (`occupancy` = DEPTH): `enq_ready` = 0. This holds even if a pop occurs in the same cycle; there is no combinational ready-from-grant path.
- Empty: `inj_bit` = 0. `inject_flit` holds the last memory contents at the read pointer, and its value is don't-care.
- No fall-through: a flit pushed into an empty queue appears on `inj_bit` the next cycle.
- Starvation counter, 8 bits:
  - Increments each cycle with `inj_bit` = 1 and `injection_status` = 0.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on any grant, and on any cycle with `inj_bit` = 0.
- `starved` = (counter == STARVE_LIMIT), registered as the counter itself. It deasserts on the edge following the grant.
- The memory array is not reset; only pointers, counter and flags are.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - pointers = 0, `occupancy` = 0.
  - `inj_bit` = 0, `enq_ready` = 1.
  - starve counter = 0, `starved` = 0.
  - `inject_flit` contents undefined.
- Reset deassertion mid-traffic: the queue restarts empty, and any flits held before reset are discarded. The PE must re-offer them.
- Enqueue-to-inject latency is 1 cycle: push at edge N gives `inj_bit` = 1 after edge N.
- `inject_flit`, `inj_bit`, `enq_ready`, `occupancy` and `starved` are all functions of registered state only, with no combinational input-to-output path. The router's injection engine is combinational, so this guarantees no combinational loop through `injection_status`.
- After a grant at edge N, the next flit (if any) is presented immediately after edge N. This allows back-to-back injection at one flit per cycle.
- Full with push attempted: the flit is not accepted, no state changes, and the PE holds `enq_flit`.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_W` default constant.
  - `flit_t` typedef (`logic [FLIT_W-1:0]`).
  - default `INJ_DEPTH` and `STARVE_LIMIT` constants, reused by the router top and by the test bench.
- One sub-module, `flit_fifo_mem`: a DEPTH×FLIT_W register array with synchronous write port and asynchronous read port, indexed by pointers.
- Pointer, occupancy and starvation logic stays in `injection_queue`.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles, released → `inj_bit` = 0, `enq_ready` = 1, `occupancy` = 0, `starved` = 0.
- Fill to full:
  - Stimulus: push 0x0000_0001..0x0000_0008 on consecutive cycles with `injection_status` = 0.
  - Required: `occupancy` = 8 and `enq_ready` = 0.
  - Then a 9th push of 0xDEAD_BEEF is rejected, and `inject_flit` = 0x0000_0001.
- Drain in order: from full, hold `injection_status` = 1 → `inject_flit` sequence is 1..8, one per cycle. After 8 grants, `inj_bit` = 0 and `occupancy` = 0.
- Simultaneous push/pop at full:
  - Stimulus: at `occupancy` = 8, assert `enq_valid` and grant together.
  - Required: pop only, `occupancy` = 7.
  - Next cycle, push plus pop together → `occupancy` stays 7.
- Wrap-around: push/pop 20 flits 0xA0..0xB3 with random gaps → output order is identical and no flit is lost or duplicated.
- Starvation:
  - Stimulus: one flit queued, grant held 0 for 15 cycles.
  - Required: `starved` = 1 after the 15th cycle.
  - A grant on cycle 16 → `starved` = 0 on the next cycle and `inj_bit` = 0.
  - Asserting reset mid-starvation clears everything immediately.
